// File: rtl/alu_pkg.sv
// Shared ALU write-back definitions: opcode width, default result width and
// the FIFO entry layout {op, zero, result}.
package alu_pkg;

  localparam int OP_W       = 4;
  localparam int DW_DEFAULT = 32;

  typedef struct packed {
    logic [OP_W-1:0]       op;
    logic                  zero;
    logic [DW_DEFAULT-1:0] result;
  } alu_entry_t;

endpackage

// File: rtl/alu_wb_fifo_if.sv
// Producer/consumer handshake bundle of the ALU write-back FIFO.
// The FIFO uses the slave modport; the ALU and consumer side use master.
interface alu_wb_fifo_if #(
  parameter int DW = alu_pkg::DW_DEFAULT
);

  logic                     in_valid;
  logic                     in_ready;
  logic [DW-1:0]            in_result;
  logic                     in_zero;
  logic [alu_pkg::OP_W-1:0] in_op;

  logic                     out_valid;
  logic                     out_ready;
  logic [DW-1:0]            out_result;
  logic                     out_zero;
  logic [alu_pkg::OP_W-1:0] out_op;

  modport master (
    output in_valid, in_result, in_zero, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_op
  );

  modport slave (
    input  in_valid, in_result, in_zero, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_op
  );

endinterface

// File: rtl/alu_wb_fifo_mem.sv
// Entry storage for the write-back FIFO: one synchronous write port and one
// asynchronous read port.
module alu_wb_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int W     = 37
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; validity is tracked by the pointers and the
  // occupancy count, so clearing it would only cost reset routing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_wb_fifo.sv
// Show-ahead FIFO buffering ALU results {op, zero, result} for write-back,
// with a sticky drop flag. Define ALU_WB_STATS_EN to add the zero_cnt output.
module alu_wb_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_wb_fifo_if.slave             bus,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef ALU_WB_STATS_EN
  ,
  output logic [15:0]              zero_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            zero;
    logic [DW-1:0]   result;
  } entry_t;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          run_q;
  logic          full, empty, push, pop;
  entry_t        wr_entry, rd_entry;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;

  // run_q holds off pushes until the edge after rst_n deassertion is seen.
  assign push = bus.in_valid && !full && run_q;
  assign pop  = bus.out_ready && !empty;

  assign wr_entry = '{op: bus.in_op, zero: bus.in_zero, result: bus.in_result};

  alu_wb_fifo_mem #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    bus.out_result = '0;
    bus.out_zero   = 1'b0;
    bus.out_op     = '0;
    if (!empty) begin
      bus.out_result = rd_entry.result;
      bus.out_zero   = rd_entry.zero;
      bus.out_op     = rd_entry.op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    ovf_q <= 1'b0;
    else if (bus.in_valid && full) ovf_q <= 1'b1;
    else if (clr_ovf)              ovf_q <= 1'b0;
  end

  assign count    = count_q;
  assign overflow = ovf_q;

`ifdef ALU_WB_STATS_EN
  logic [15:0] zero_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        zero_cnt_q <= '0;
    else if (clr_ovf)                                  zero_cnt_q <= '0;
    else if (push && bus.in_zero && zero_cnt_q != '1)  zero_cnt_q <= zero_cnt_q + 1'b1;
  end

  assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_alu_wb_fifo.sv
// Randomised and directed bench for alu_wb_fifo against a queue-based model.
// Builds with or without ALU_WB_STATS_EN.
module tb_alu_wb_fifo;
  import alu_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_ovf;
  logic [3:0] count;
  logic       overflow;
`ifdef ALU_WB_STATS_EN
  logic [15:0] zero_cnt;
`endif

  alu_wb_fifo_if #(.DW(32)) bus ();

  alu_wb_fifo #(.DEPTH(DEPTH), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .overflow (overflow)
`ifdef ALU_WB_STATS_EN
    ,
    .zero_cnt (zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  alu_entry_t  q[$];
  bit          m_ovf;
  int          m_edges;
  int unsigned m_zc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_edges = 0;
    m_zc    = 0;
  endtask

  task automatic model_edge(input bit iv, input logic [31:0] res, input bit z,
                            input logic [3:0] op, input bit ordy, input bit clr);
    bit full, do_push, do_pop;
    full    = (q.size() == DEPTH);
    do_push = iv && !full && (m_edges >= 1);
    do_pop  = ordy && (q.size() > 0);
    if (iv && full) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    if (clr) m_zc = 0;
    else if (do_push && z && m_zc < 65535) m_zc++;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back('{op: op, zero: z, result: res});
    m_edges++;
  endtask

  task automatic check_all();
    check("count", count, q.size());
    check("in_ready", bus.in_ready, q.size() != DEPTH);
    check("out_valid", bus.out_valid, q.size() != 0);
    check("overflow", overflow, m_ovf);
    if (q.size() > 0) begin
      check("out_result", bus.out_result, q[0].result);
      check("out_zero", bus.out_zero, q[0].zero);
      check("out_op", bus.out_op, q[0].op);
    end else begin
      check("out_known", $isunknown({bus.out_result, bus.out_zero, bus.out_op}), 0);
    end
`ifdef ALU_WB_STATS_EN
    check("zero_cnt", zero_cnt, m_zc);
`endif
  endtask

  task automatic step(input bit iv, input logic [31:0] res, input bit z,
                      input logic [3:0] op, input bit ordy, input bit clr);
    bus.in_valid  = iv;
    bus.in_result = res;
    bus.in_zero   = z;
    bus.in_op     = op;
    bus.out_ready = ordy;
    clr_ovf       = clr;
    @(posedge clk);
    model_edge(iv, res, z, op, ordy, clr);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, '0, 1'b0, '0, ordy, 1'b0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_zero = 1'b0;
    bus.in_op = '0; bus.out_ready = 1'b0; clr_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH && q.size() > 0; i++) idle(1'b1);
    check("drained", count, 0);
  endtask

  initial begin
    logic [31:0] vals [3];
    logic [31:0] got_seq [$];
    logic [31:0] exp_seq [$];
    logic [31:0] r;

    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_zero = 1'b0;
    bus.in_op = '0; bus.out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();

    // Reset values while rst_n is held low from time zero
    #2;
    check("rst_count", count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_fields", {bus.out_result, bus.out_zero, bus.out_op}, 0);
    check("rst_overflow", overflow, 0);
    do_reset();
    idle(1'b0);

    // Three pushes held with out_ready low
    vals[0] = 32'h1; vals[1] = 32'h0; vals[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) step(1'b1, vals[i], vals[i] == 0, 4'(i + 1), 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("hold_count", count, 3);
    check("hold_head", bus.out_result, 32'h1);
    drain();

    // Fill to DEPTH, drop a ninth, then clear/set race on overflow
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 32'(i), 1'b0, 4'h3, 1'b0, 1'b0);
    check("full_in_ready", bus.in_ready, 0);
    step(1'b1, 32'hDEAD, 1'b0, 4'h3, 1'b0, 1'b0);
    check("drop_ovf", overflow, 1);
    check("drop_count", count, DEPTH);
    step(1'b1, 32'hDEAD, 1'b0, 4'h3, 1'b0, 1'b1);
    check("clr_vs_set", overflow, 1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("clr_alone", overflow, 0);
    for (int i = 1; i <= DEPTH; i++) begin
      check("pop_order", bus.out_result, 32'(i));
      idle(1'b1);
    end
    check("empty_after", bus.out_valid, 0);

    // Steady-state push+pop at count 4 across pointer wrap
    got_seq.delete(); exp_seq.delete();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(100 + i), 1'b0, 4'h5, 1'b0, 1'b0);
      exp_seq.push_back(32'(100 + i));
    end
    for (int i = 0; i < 20; i++) begin
      got_seq.push_back(bus.out_result);
      exp_seq.push_back(32'(200 + i));
      step(1'b1, 32'(200 + i), 1'b0, 4'h6, 1'b1, 1'b0);
      check("steady_count", count, 4);
    end
    for (int i = 0; i < 20; i++) check("steady_order", got_seq[i], exp_seq[i]);
    drain();

    // Asynchronous reset with five entries stored
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 4'h7, 1'b0, 1'b0);
    check("pre_rst_count", count, 5);
    #1 rst_n = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_out_valid", bus.out_valid, 0);
    check("async_in_ready", bus.in_ready, 1);
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0);

`ifdef ALU_WB_STATS_EN
    for (int i = 0; i < 5; i++) begin
      r = (i == 1 || i == 3) ? 32'h0 : 32'(i + 10);
      step(1'b1, r, r == 0, 4'h2, 1'b0, 1'b0);
    end
    check("zc_two", zero_cnt, 2);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    check("zc_clr", zero_cnt, 0);
    drain();
`endif

    // Random traffic: first half leans toward full, second toward empty
    for (int i = 0; i < 800; i++) begin
      bit iv, ordy, clr, z;
      r    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      z    = (r == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      clr  = ($urandom_range(0, 15) == 0);
      step(iv, r, z, 4'($urandom), ordy, clr);
      if (i == 600) begin
        do_reset();
        idle(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
